id_stream_arb: RTL
==================

# id_stream_arb

Shares one identifier-suffix recognizer between two character-stream requesters at string granularity. Round-robin arbitration grants one requester per string, resets the recognizer at string start, and feeds it accepted characters. After each string it reports whether the string ended in a letter-run followed by a digit-run. Optional per-requester match counters. Sits between the two character sources and downstream result logic.

## Interface
- `CNT_W`, default 8: width of the per-requester match counters.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  requester n presents a character.
- `req0_char`, `req1_char`  in  8  ASCII character of requester n.
- `req0_last`, `req1_last`  in  1  character is the final one of the string.
- `req0_ready`, `req1_ready`  out  1  character accepted this cycle when valid & ready.
- `busy`  out  1  arbiter in RUN.
- `gnt_id`  out  1  requester currently granted; meaningful only while busy.
- `done`  out  1  one-cycle pulse: string result available.
- `done_id`  out  1  requester whose string completed.
- `done_match`  out  1  recognizer was in S2 after the final character.
- `cnt0`, `cnt1`  out  CNT_W  per-requester match counts.

## Operation
- Character classes:
  - Letter: 65–90 or 97–122.
  - Digit: 48–57.
  - Other: everything else.
- Recognizer states S0 / S1 / S2; advances only on an accepted character.
  - S0: letter -> S1; otherwise S0.
  - S1 or S2: letter -> S1; digit -> S2; other -> S0.
- Arbiter FSM:
  - IDLE:
    - Both ready outputs 0.
    - If any `reqN_valid`: grant requester `ptr` if its valid is high, else the other one.
    - Load `gnt_id`, clear recognizer to S0, go to RUN.
  - RUN:
    - `reqN_ready` = (gnt_id == N), combinational from state; non-granted ready is 0.
    - Valid high on the granted side: character accepted, recognizer updated.
    - Accepted character with `last`=1:
      - Go to IDLE; set `ptr` to the other requester.
      - Next cycle: `done`=1, `done_id`=gnt_id, `done_match`=(updated recognizer state == S2).
- Valid low while granted: recognizer holds, no timeout, grant held.
- Non-granted requester inputs are ignored and never alter state.
- Reset values:
  - FSM IDLE, recognizer S0, `ptr`=0.
  - `busy`, `gnt_id`, `done`, `done_id`, `done_match`, all ready = 0.
  - `cnt0`, `cnt1` = 0.
- Reset mid-string: string abandoned, no `done` pulse, `ptr` returns to 0.

## Timing
- Grant latency: one cycle. Valid seen in IDLE at edge k; ready high in cycle k+1.
- Throughput: one character per cycle during RUN.
- Result latency: `done` is high in the cycle after the final character is accepted.
  - That cycle is the IDLE cycle, so at least one bubble separates consecutive strings.
- `done`, `done_id`, `done_match` are registered.
  - `done_id` and `done_match` hold their value until the next `done`.
- Single-character string (`last` on first accept): `done_match`=0, since S2 is unreachable in one step.
- Both valid in IDLE: `ptr` side wins. After each completion, priority flips to the other requester.
- A requester with valid held high continuously is served on alternate strings when the other is also valid.

## Configuration
- `ID_ARB_CNT_EN` defined:
  - `cnt0`/`cnt1` increment by 1 in the `done` cycle when `done_match`=1 and `done_id` selects them.
  - Counters saturate at 2^CNT_W−1; no wrap.
- `ID_ARB_CNT_EN` undefined:
  - Counter logic is absent; `cnt0`/`cnt1` are tied to 0.
  - All other behaviour is unchanged.

## Test plan
- Req0 sends "ab12" (`last` on '2'), req1 idle -> one cycle after '2' is accepted: `done`=1, `done_id`=0, `done_match`=1; `cnt0`=1 with macro, 0 without.
- Req1 sends "a1b" -> `done_match`=0 (final state S1); req1 sends "9x_3" -> `done_match`=0 (S0 after '_', '3' keeps S0).
- Both valid from reset, each sending "x9" repeatedly -> grants strictly alternate 0,1,0,1; `done_id` alternates; no character from the non-granted side is accepted (its ready stays 0).
- Req0 sends 'A', drops valid for 5 cycles, then sends '7' with `last` -> grant held, `req1_ready` stays 0 throughout, `done_match`=1.
- Assert `reset` after "ab" of "ab12" is accepted -> all outputs 0 next cycle, no `done`. Resend "12" alone -> `done_match`=0 (recognizer restarted at S0).
- With `ID_ARB_CNT_EN` and `CNT_W`=2, req0 sends "a1" five times -> `cnt0` reads 1,2,3,3,3.

Source files
------------

// File: rtl/id_stream_arb.sv
// id_stream_arb: two character-stream requesters share one identifier-suffix
// recognizer at string granularity, with round-robin grant per string.
// Each completed string produces a registered done pulse. The pulse carries
// the requester id and whether the string ended in a letter-run followed by
// a digit-run.
// Optional feature macro: ID_ARB_CNT_EN adds saturating per-requester match
// counters. Without it, cnt0/cnt1 are tied to zero.
//
// Handshake: a character moves on a rising edge when reqN_valid && reqN_ready.
// Ready depends only on arbiter state, never on valid. A requester may drop
// valid at any time without losing its grant. A character accepted with
// reqN_last set closes the string.
module id_stream_arb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  input  logic             req0_last,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  input  logic             req1_last,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic             busy,
  output logic             gnt_id,
  output logic             done,
  output logic             done_id,
  output logic             done_match,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic [1:0] {S0, S1, S2} rec_t;

  state_t state_q, state_d;
  rec_t   rec_q, rec_d, rec_upd;
  logic   gnt_q, gnt_d;
  logic   ptr_q, ptr_d;
  logic   done_q, done_d;
  logic   done_id_q, done_id_d;
  logic   done_match_q, done_match_d;

  logic       sel_valid;
  logic [7:0] sel_char;
  logic       sel_last;

  // Recognizer step. A letter always (re)starts a letter-run. Digits only
  // extend a run that began with a letter. Anything else drops back to S0.
  function automatic rec_t rec_next(input rec_t s, input logic [7:0] c);
    logic is_l, is_d;
    is_l = ((c >= 8'd65) && (c <= 8'd90)) || ((c >= 8'd97) && (c <= 8'd122));
    is_d = (c >= 8'd48) && (c <= 8'd57);
    if (is_l)         return S1;
    else if (s == S0) return S0;
    else if (is_d)    return S2;
    else              return S0;
  endfunction

  // Route the granted requester's inputs to the recognizer.
  always_comb begin
    sel_valid = gnt_q ? req1_valid : req0_valid;
    sel_char  = gnt_q ? req1_char  : req0_char;
    sel_last  = gnt_q ? req1_last  : req0_last;
    rec_upd   = rec_next(rec_q, sel_char);
  end

  // Arbiter next-state, recognizer update and result capture.
  always_comb begin
    state_d      = state_q;
    rec_d        = rec_q;
    gnt_d        = gnt_q;
    ptr_d        = ptr_q;
    done_d       = 1'b0;
    done_id_d    = done_id_q;
    done_match_d = done_match_q;
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          // The ptr side wins if it is asking; otherwise the other side does.
          gnt_d   = ptr_q ? req1_valid : !req0_valid;
          rec_d   = S0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (sel_valid) begin
          rec_d = rec_upd;
          if (sel_last) begin
            state_d      = IDLE;
            ptr_d        = !gnt_q;
            done_d       = 1'b1;
            done_id_d    = gnt_q;
            done_match_d = (rec_upd == S2);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rec_q        <= S0;
      gnt_q        <= 1'b0;
      ptr_q        <= 1'b0;
      done_q       <= 1'b0;
      done_id_q    <= 1'b0;
      done_match_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rec_q        <= rec_d;
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      done_q       <= done_d;
      done_id_q    <= done_id_d;
      done_match_q <= done_match_d;
    end
  end

  assign busy       = (state_q == RUN);
  assign gnt_id     = gnt_q;
  assign req0_ready = (state_q == RUN) && !gnt_q;
  assign req1_ready = (state_q == RUN) && gnt_q;
  assign done       = done_q;
  assign done_id    = done_id_q;
  assign done_match = done_match_q;

`ifdef ID_ARB_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  // Count matching strings per requester during the done cycle, saturating.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (done_q && done_match_q) begin
      if (!done_id_q && (cnt0_q != CNT_MAX)) cnt0_q <= cnt0_q + CNT_ONE;
      if (done_id_q && (cnt1_q != CNT_MAX))  cnt1_q <= cnt1_q + CNT_ONE;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule
